// File: rtl/ps2_key_buffer_pkg.sv
// Shared types and helpers for the PS/2 hex-key buffer: prefix codes,
// receiver states, scancode lookup and frame parity check.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } key_map_t;

    // Set-2 make codes of the hex keys 0-9, A-F.
    function automatic key_map_t scan_to_nibble(input logic [7:0] sc);
        key_map_t m;
        m.valid  = 1'b1;
        m.nibble = 4'h0;
        case (sc)
            8'h45:   m.nibble = 4'h0;
            8'h16:   m.nibble = 4'h1;
            8'h1E:   m.nibble = 4'h2;
            8'h26:   m.nibble = 4'h3;
            8'h25:   m.nibble = 4'h4;
            8'h2E:   m.nibble = 4'h5;
            8'h36:   m.nibble = 4'h6;
            8'h3D:   m.nibble = 4'h7;
            8'h3E:   m.nibble = 4'h8;
            8'h46:   m.nibble = 4'h9;
            8'h1C:   m.nibble = 4'hA;
            8'h32:   m.nibble = 4'hB;
            8'h21:   m.nibble = 4'hC;
            8'h23:   m.nibble = 4'hD;
            8'h24:   m.nibble = 4'hE;
            8'h2B:   m.nibble = 4'hF;
            default: m.valid  = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_key_buffer_if.sv
// Key FIFO consumer port: pop request in, FWFT head and occupancy out.
interface ps2_key_buffer_if #(
    parameter int FIFO_DEPTH = 8
) ();
    logic                          key_pop;
    logic                          key_valid;
    logic [3:0]                    key_code;
    logic [$clog2(FIFO_DEPTH):0]   key_count;

    modport master (output key_pop, input key_valid, key_code, key_count);
    modport slave  (input key_pop, output key_valid, key_code, key_count);
endinterface

// File: rtl/ps2_key_buffer_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect,
// start/data/parity/stop FSM and an in-frame idle timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 27000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]  r_clk_sync;
    logic [1:0]  r_dat_sync;
    logic        w_fe;
    logic        w_dat;
    rx_state_t   r_state, w_state_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_par, w_par_nxt;
    logic [TW-1:0] r_to_cnt;
    logic        w_timeout;
    logic        w_good, w_err;
    logic        r_rx_valid, r_frame_err;

    // [2] is the previous value of the second sync stage, for edge detect.
    assign w_fe      = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_dat     = r_dat_sync[1];
    assign w_timeout = (r_state != IDLE) && (r_to_cnt == TW'(TIMEOUT_CYC));

    // Two-flop synchronisers, idle-high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
        end
    end

    // Idle-cycle counter inside a frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || r_state == IDLE || w_fe) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    // Next-state and frame outcome.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_good        = 1'b0;
        w_err         = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
        end else if (w_fe) begin
            case (r_state)
                IDLE: begin
                    if (!w_dat) begin
                        w_state_nxt   = DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                DATA: begin
                    w_shift_nxt = {w_dat, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    w_par_nxt   = w_dat;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    if (w_dat && odd_parity_ok(r_shift, r_par)) begin
                        w_good = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_par       <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par       <= w_par_nxt;
            r_rx_valid  <= w_good;
            r_frame_err <= w_err;
        end
    end

    assign o_rx_byte   = r_shift;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 hex-key buffer: prefix tracking, FWFT key FIFO and digit history.
// NUM_DIGITS must be at least 2.
module ps2_key_buffer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 27000
) (
    input  logic                    CLOCK_27,
    input  logic                    RESET_N,
    input  logic                    PS2_CLK,
    input  logic                    PS2_DAT,
    ps2_key_buffer_if.slave         key_if,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    overflow,
    output logic                    frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]  w_rx_byte;
    logic        w_rx_valid;
    key_map_t    w_map;
    logic        r_brk, r_ext, w_brk_nxt, w_ext_nxt;
    logic        r_push, w_push_nxt;
    logic [3:0]  r_push_code, w_code_nxt;
    logic [3:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic        w_full, w_empty, w_do_push, w_do_pop;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic        r_overflow;

    ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .i_clk       (CLOCK_27),
        .i_rst_n     (RESET_N),
        .i_ps2_clk   (PS2_CLK),
        .i_ps2_dat   (PS2_DAT),
        .o_rx_byte   (w_rx_byte),
        .o_rx_valid  (w_rx_valid),
        .o_frame_err (frame_err)
    );

    assign w_map = scan_to_nibble(w_rx_byte);

    // A byte following a break or extended prefix is swallowed.
    always_comb begin
        w_brk_nxt  = r_brk;
        w_ext_nxt  = r_ext;
        w_push_nxt = 1'b0;
        w_code_nxt = r_push_code;
        if (w_rx_valid) begin
            if (w_rx_byte == SC_BREAK) begin
                w_brk_nxt = 1'b1;
            end else if (w_rx_byte == SC_EXT) begin
                w_ext_nxt = 1'b1;
            end else if (r_brk || r_ext) begin
                w_brk_nxt = 1'b0;
                w_ext_nxt = 1'b0;
            end else if (w_map.valid) begin
                w_push_nxt = 1'b1;
                w_code_nxt = w_map.nibble;
            end else begin
                w_push_nxt = 1'b0;
            end
        end else begin
            w_push_nxt = 1'b0;
        end
    end

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == CW'(0));
    assign w_do_pop  = key_if.key_pop && !w_empty;
    assign w_do_push = r_push && (!w_full || w_do_pop);

    // Prefix flags, push stage, FIFO pointers, history and overflow.
    always_ff @(posedge CLOCK_27) begin
        if (!RESET_N) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_push      <= 1'b0;
            r_push_code <= 4'h0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_digits    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_brk       <= w_brk_nxt;
            r_ext       <= w_ext_nxt;
            r_push      <= w_push_nxt;
            r_push_code <= w_code_nxt;
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (r_push) r_digits <= {r_digits[4*NUM_DIGITS-5:0], r_push_code};
            if (r_push && w_full && !w_do_pop) r_overflow <= 1'b1;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge CLOCK_27) begin
        if (w_do_push) r_mem[r_wr_ptr] <= r_push_code;
    end

    assign key_if.key_valid = !w_empty;
    assign key_if.key_code  = w_empty ? 4'h0 : r_mem[r_rd_ptr];
    assign key_if.key_count = r_count;
    assign digits           = r_digits;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Randomised scoreboard bench for ps2_key_buffer with a queue-based reference model.
module tb_ps2_key_buffer;
    localparam int DEPTH = 8;
    localparam int ND    = 4;
    localparam int TO    = 27000;
    localparam int H     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic [4*ND-1:0] digits;
    logic overflow, frame_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int exp_err = 0;
    logic [3:0] exp_q[$];
    logic [15:0] exp_digits = 16'h0000;
    bit exp_ovf = 1'b0;
    bit m_brk = 1'b0;
    bit m_ext = 1'b0;
    logic [3:0] keymap [logic [7:0]];
    logic [7:0] sc_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    ps2_key_buffer_if #(.FIFO_DEPTH(DEPTH)) key_if ();

    ps2_key_buffer #(.FIFO_DEPTH(DEPTH), .NUM_DIGITS(ND), .TIMEOUT_CYC(TO)) dut (
        .CLOCK_27  (clk),
        .RESET_N   (rst_n),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .key_if    (key_if),
        .digits    (digits),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts error pulses and scores every pop against the model queue.
    always @(negedge clk) begin
        if (rst_n && frame_err) err_seen++;
        if (rst_n && key_if.key_pop) begin
            if (exp_q.size() > 0) begin
                chk("pop_valid", int'(key_if.key_valid), 1);
                chk("pop_code", int'(key_if.key_code), int'(exp_q[0]));
                void'(exp_q.pop_front());
            end else begin
                chk("pop_empty_valid", int'(key_if.key_valid), 0);
                chk("pop_empty_code", int'(key_if.key_code), 0);
            end
        end
    end

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (m_brk || m_ext) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (keymap.exists(b)) begin
            exp_digits = {exp_digits[11:0], keymap[b]};
            if (exp_q.size() < DEPTH) exp_q.push_back(keymap[b]);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_at_push, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2_dat = f[i];
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10 && pop_at_push) begin
                repeat (4) @(posedge clk);
                #1 key_if.key_pop = 1'b1;
                @(posedge clk); #1 key_if.key_pop = 1'b0;
                repeat (H - 5) @(posedge clk);
            end else begin
                repeat (H) @(posedge clk);
            end
            #1 ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (8) @(posedge clk);
        if (nbits == 11) begin
            if (bad_par || bad_stop) exp_err++;
            else model_byte(b);
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 11);
    endtask

    task automatic pop_one();
        @(posedge clk); #1 key_if.key_pop = 1'b1;
        @(posedge clk); #1 key_if.key_pop = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        exp_digits = 16'h0000;
        exp_ovf = 1'b0;
        m_brk = 1'b0;
        m_ext = 1'b0;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, int'(key_if.key_count), exp_q.size());
        chk({tag, "_valid"}, int'(key_if.key_valid), (exp_q.size() > 0) ? 1 : 0);
        chk({tag, "_code"}, int'(key_if.key_code), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
        chk({tag, "_digits"}, int'(digits), int'(exp_digits));
        chk({tag, "_ovf"}, int'(overflow), int'(exp_ovf));
        chk({tag, "_ferr"}, err_seen, exp_err);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        key_if.key_pop = 1'b0;
        for (int i = 0; i < 16; i++) keymap[sc_tab[i]] = 4'(i);
        repeat (3) @(posedge clk);
        do_reset();
        check_state("reset");

        send(8'h16);
        check_state("key1");
        pop_one();
        check_state("key1_pop");

        send(8'h1C); send(8'hF0); send(8'h1C);
        check_state("break");
        pop_one();
        send(8'hE0); send(8'h45);
        check_state("ext");
        send(8'h45);
        check_state("after_ext");
        pop_one();

        send_frame(8'h2E, 1'b1, 1'b0, 1'b0, 11);
        check_state("bad_par");
        send_frame(8'h2E, 1'b0, 1'b1, 1'b0, 11);
        check_state("bad_stop");
        send_frame(8'h26, 1'b0, 1'b0, 1'b0, 4);
        repeat (TO + 100) @(posedge clk);
        exp_err++;
        check_state("timeout");
        send(8'h3E);
        check_state("after_to");
        pop_one();

        for (int i = 0; i < 9; i++) send(sc_tab[i]);
        check_state("overflow");
        chk("overflow_digits", int'(digits), 16'h5678);

        do_reset();
        for (int i = 0; i < 8; i++) send(sc_tab[i]);
        send_frame(8'h2B, 1'b0, 1'b0, 1'b1, 11);
        check_state("full_pushpop");
        for (int i = 0; i < 8; i++) pop_one();
        check_state("drained");
        pop_one();
        check_state("pop_empty");

        for (int it = 0; it < 20; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                6: begin send(8'hF0); send(sc_tab[$urandom_range(0, 15)]); end
                7: begin send(8'hE0); send(sc_tab[$urandom_range(0, 15)]); end
                8: begin
                    b = 8'($urandom_range(0, 255));
                    while (keymap.exists(b) || b == 8'hF0 || b == 8'hE0) b = 8'($urandom_range(0, 255));
                    send_frame(b, $urandom_range(0, 1) == 1, 1'b0, 1'b0, 11);
                end
                9: pop_one();
                default: send(sc_tab[$urandom_range(0, 15)]);
            endcase
            check_state("rand");
        end

        send_frame(8'h46, 1'b0, 1'b0, 1'b0, 5);
        do_reset();
        check_state("mid_reset");
        send(8'h46);
        check_state("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_buffer.md
Name: ps2_key_buffer

Overview:
- Parametrised successor to the single-character PS/2 keyboard path.
- Receives PS/2 set-2 frames, checks parity and timeout, and tracks make/break/extended prefixes.
- Maps hex-digit keys (0-9, A-F) to 4-bit codes, queues them in a first-word-fall-through FIFO for the chess input logic, and keeps a scrolling history of the last NUM_DIGITS keys for the HEX displays.

Parameters:
- FIFO_DEPTH, 8, number of queued key codes; power of two, 2 or more.
- NUM_DIGITS, 4, number of history nibbles driven to the hex displays.
- TIMEOUT_CYC, 27000, idle CLOCK_27 cycles inside a frame before the frame is abandoned (1 ms).

Ports:
- CLOCK_27  in  1  system clock, 27 MHz.
- RESET_N  in  1  synchronous, active-low reset; one clock; no other clock domain.
- PS2_CLK  in  1  raw PS/2 clock, asynchronous.
- PS2_DAT  in  1  raw PS/2 data, asynchronous.
- key_pop  in  1  consume FIFO head this cycle.
- key_valid  out  1  FIFO not empty.
- key_code  out  4  FIFO head (FWFT); 0 when empty.
- key_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- digits  out  4*NUM_DIGITS  key history; [3:0] = newest.
- overflow  out  1  sticky: a key was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset (RESET_N low at a clock edge), regardless of any frame in progress:
  - receiver returns to IDLE; break and ext flags cleared;
  - FIFO emptied; digits = 0; overflow = 0; frame_err = 0; key_code = 0; key_count = 0.
- Input sync: PS2_CLK and PS2_DAT each pass through 2 flops. A falling edge (fe) is registered when the synchronised clock goes 1->0; all sampling happens on fe.
- Receiver FSM:
  - IDLE: on fe with dat=0 -> DATA, bit counter = 0. On fe with dat=1, stay in IDLE (glitch).
  - DATA: on each fe, shift dat in LSB first; after the 8th bit -> PARITY.
  - PARITY: on fe, latch the bit -> STOP.
  - STOP: on fe, if dat=1 and (data XOR-reduced XOR parity)=1, i.e. odd parity, the byte is good; otherwise pulse frame_err. Either way -> IDLE.
  - Timeout: a cycle counter is cleared on every fe. If it reaches TIMEOUT_CYC while not in IDLE -> IDLE and pulse frame_err.
- Byte valid: rx_valid pulses for 1 cycle at T+1, where T is the cycle in which the stop-bit fe is registered.
- Byte decode, at rx_valid:
  - 0xF0: set break.
  - 0xE0: set ext.
  - Any other byte: if break or ext is set, discard it and clear both flags. Otherwise look it up.
  - Lookup (make codes): 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9, 1C->A, 32->B, 21->C, 23->D, 24->E, 2B->F. Unmapped bytes are ignored.
  - A mapped key produces push at T+2.
- History: on every mapped key, digits <= {digits[4*NUM_DIGITS-5:0], code}, even if the FIFO is full. The oldest nibble falls off.
- FIFO:
  - Write and read pointers of $clog2(FIFO_DEPTH) bits wrap modulo FIFO_DEPTH; count is tracked separately.
  - push with count < FIFO_DEPTH: write.
  - push when full and no pop: drop the key, set overflow; overflow clears only on reset.
  - push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
  - push and pop in the same cycle when empty: push only; the pop is ignored.
  - pop when empty: ignored, no state change.
  - key_code is combinational from the head entry (0 when empty), so a pushed key is visible together with key_valid.
- Latency: stop-bit fe in cycle T -> key_valid, key_code and digits update at the T+2 edge (visible in T+3).

Decomposition:
- Package ps2_pkg:
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0;
  - receiver state enum {IDLE, DATA, PARITY, STOP};
  - the scancode-to-nibble function, returning a valid bit and a nibble.
- Sub-module ps2_frame_rx: sync, edge detect, FSM, timeout. Outputs rx_byte, rx_valid and the frame_err pulse.
- The top level holds the prefix flags, the FIFO and the history register.

Test Plan:
- Reset then send frame 0x16 (good parity): key_valid=1, key_code=1, digits[3:0]=1, key_count=1 at T+3. Then pulse key_pop: key_valid=0, key_code=0.
- Send 0x1C, then F0 1C: exactly one key A queued. Send E0 45: nothing queued, and the flags are clear afterwards. A following 0x45 queues 0.
- Send 0x2E with the parity bit flipped: frame_err pulses once, no push. Send a frame with stop bit=0: same. Stall PS2_CLK after 3 data bits for more than 27000 cycles: frame_err pulses, FSM is in IDLE, and the next good 0x3E queues 8.
- With FIFO_DEPTH=8, queue 9 keys (0-8) without popping: the 9th sets overflow, key_count=8, head=0. digits (NUM_DIGITS=4) = 0x5678.
- Full FIFO, with key_pop asserted in the same cycle as a push of F: count stays 8, overflow stays 0, and the new head is 1. Pop on an empty FIFO: no change. Drive RESET_N low mid-frame: all outputs return to reset values, and the next complete frame decodes correctly.
